// File: rtl/gpio_pkg.sv
// Shared constants, FSM encoding and byte-select helpers for the GPIO input capture block.
package gpio_pkg;

    localparam int unsigned GPIO_WIDTH    = 32;
    localparam int unsigned COUNT_WIDTH   = 16;
    localparam int unsigned KEY_WIDTH     = 4;
    localparam int unsigned SW_WIDTH      = 10;
    localparam int unsigned LED_WIDTH     = 10;
    localparam int unsigned KEY_CLEAR_BIT = 1;

    typedef enum logic {
        StStable  = 1'b0,
        StPending = 1'b1
    } deb_state_e;

    typedef enum logic [1:0] {
        ByteSel0 = 2'b00,
        ByteSel1 = 2'b01,
        ByteSel2 = 2'b10,
        ByteSel3 = 2'b11
    } byte_sel_e;

    function automatic logic [7:0] select_byte(input logic [GPIO_WIDTH-1:0] word,
                                               input logic [1:0]            sel);
        logic [7:0] b;
        case (sel)
            ByteSel0: b = word[7:0];
            ByteSel1: b = word[15:8];
            ByteSel2: b = word[23:16];
            ByteSel3: b = word[31:24];
            default:  b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flip-flop synchronizer with a configurable synchronous reset value.
module gpio_sync #(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_in_capture.sv
// Synchronizes and debounces a 32-bit GPIO word, tracks sticky per-bit change flags and a
// saturating update count, and drives a registered LED status view.
module gpio_in_capture
    import gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                   CLOCK_50,
    input  logic                   Reset,
    input  logic [GPIO_WIDTH-1:0]  GPIO,
    input  logic [KEY_WIDTH-1:0]   KEY,
    input  logic [SW_WIDTH-1:0]    SW,
    output logic [GPIO_WIDTH-1:0]  gpio_value,
    output logic [GPIO_WIDTH-1:0]  change_flags,
    output logic [COUNT_WIDTH-1:0] change_count,
    output logic [LED_WIDTH-1:0]   LEDR
);

    localparam logic [COUNT_WIDTH-1:0] DEB_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [GPIO_WIDTH-1:0]  gpio_s;
    logic [KEY_WIDTH-1:0]   key_s;

    deb_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0] deb_cnt_q, deb_cnt_d;
    logic [GPIO_WIDTH-1:0]  prev_q;
    logic [GPIO_WIDTH-1:0]  value_q, value_d;
    logic [GPIO_WIDTH-1:0]  flags_q, flags_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [LED_WIDTH-1:0]   ledr_q, ledr_d;

    logic                   qualified;
    logic                   accept;
    logic                   clear;
    logic [GPIO_WIDTH-1:0]  set_bits;
    logic                   unused_inputs;

    gpio_sync #(
        .WIDTH       (GPIO_WIDTH),
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE ({GPIO_WIDTH{1'b0}})
    ) u_gpio_sync (
        .clk   (CLOCK_50),
        .reset (Reset),
        .din   (GPIO),
        .dout  (gpio_s)
    );

    // Keys are active-low, so the reset value models released buttons.
    gpio_sync #(
        .WIDTH       (KEY_WIDTH),
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE ({KEY_WIDTH{1'b1}})
    ) u_key_sync (
        .clk   (CLOCK_50),
        .reset (Reset),
        .din   (KEY),
        .dout  (key_s)
    );

    assign unused_inputs = ^{SW[7:1], key_s[3:2], key_s[0]};
    assign clear         = ~key_s[KEY_CLEAR_BIT];

    // Stability counter; holds at its terminal value so a long-stable word never wraps.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if (gpio_s != prev_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_LAST) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    assign qualified = (deb_cnt_d == DEB_LAST);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            StStable: begin
                if (gpio_s != value_q) begin
                    if (qualified) begin
                        accept = 1'b1;
                    end else begin
                        state_d = StPending;
                    end
                end
            end
            StPending: begin
                if (gpio_s == value_q) begin
                    state_d = StStable;
                end else if (qualified) begin
                    accept  = 1'b1;
                    state_d = StStable;
                end
            end
            default: state_d = StStable;
        endcase
    end

    // An accepting edge wins over a simultaneous clear for the bits it changes.
    always_comb begin
        set_bits = accept ? (value_q ^ gpio_s) : '0;
        value_d  = accept ? gpio_s : value_q;
        flags_d  = clear ? set_bits : (flags_q | set_bits);
        count_d  = count_q;
        if (accept && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_comb begin
        ledr_d      = '0;
        ledr_d[7:0] = select_byte(SW[0] ? flags_q : value_q, SW[9:8]);
        ledr_d[8]   = (state_q == StPending);
        ledr_d[9]   = |flags_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q   <= StStable;
            deb_cnt_q <= '0;
            prev_q    <= '0;
            value_q   <= '0;
            flags_q   <= '0;
            count_q   <= '0;
            ledr_q    <= '0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            prev_q    <= gpio_s;
            value_q   <= value_d;
            flags_q   <= flags_d;
            count_q   <= count_d;
            ledr_q    <= ledr_d;
        end
    end

    assign gpio_value   = value_q;
    assign change_flags = flags_q;
    assign change_count = count_q;
    assign LEDR         = ledr_q;

endmodule
